// File: rtl/vol_sched_pkg.sv
// Shared types and defaults for the volatility scheduler slice.
package vol_sched_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} sched_state_t;

    localparam int unsigned DEF_NUM_STOCKS  = 4;
    localparam int unsigned DEF_BUFFER_SIZE = 32;
    localparam int unsigned ADDR_W          = $clog2(DEF_NUM_STOCKS * DEF_BUFFER_SIZE);
    localparam int unsigned ID_W            = $clog2(DEF_NUM_STOCKS);
    localparam logic [63:0] RECIP_Q32       = 64'h1_0000_0000 / 64'(DEF_BUFFER_SIZE);

    // Q32.32 reciprocal of the window length, truncated.
    function automatic logic [63:0] recip_q32(input int unsigned bs);
        return 64'h1_0000_0000 / 64'(bs);
    endfunction

endpackage

// File: rtl/volatility_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority pointer.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [N-1:0]         i_req,
    input  logic                 i_advance,
    output logic [N-1:0]         o_grant_onehot,
    output logic [$clog2(N)-1:0] o_grant_idx
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        o_grant_onehot = '0;
        o_grant_idx    = '0;
        found          = 1'b0;
        idx            = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ptr_q + IW'(k);
            if (!found && i_req[idx]) begin
                found       = 1'b1;
                o_grant_idx = idx;
            end
        end
        if (found) o_grant_onehot[o_grant_idx] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            ptr_q <= '0;
        end else if (i_advance && found) begin
            ptr_q <= o_grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/volatility_scheduler.sv
// Arbitrates per-stock price updates onto one shared volatility memory and
// registers the memory's response for the pricing stage.
module volatility_scheduler
    import vol_sched_pkg::*;
#(
    parameter int unsigned FP_WORD_SIZE = 64,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BUFFER_SIZE  = DEF_BUFFER_SIZE,
    parameter int unsigned NUM_STOCKS   = DEF_NUM_STOCKS,
    parameter int unsigned TIMEOUT      = 4
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset_n,
    input  logic [NUM_STOCKS-1:0]                     i_req,
    input  logic [NUM_STOCKS*DATA_WIDTH-1:0]          i_best_ask,
    input  logic [NUM_STOCKS*DATA_WIDTH-1:0]          i_best_bid,
    output logic [NUM_STOCKS-1:0]                     o_ready,
    output logic [$clog2(NUM_STOCKS*BUFFER_SIZE)-1:0] o_mem_write_address,
    output logic [DATA_WIDTH-1:0]                     o_mem_best_ask,
    output logic [DATA_WIDTH-1:0]                     o_mem_best_bid,
    output logic [$clog2(NUM_STOCKS)-1:0]             o_mem_stock_id,
    output logic                                      o_mem_valid,
    output logic [DATA_WIDTH-1:0]                     o_mem_buffer_size,
    output logic [FP_WORD_SIZE-1:0]                   o_mem_buffer_size_reciprocal,
    input  logic [FP_WORD_SIZE-1:0]                   i_mem_volatility,
    input  logic [DATA_WIDTH-1:0]                     i_mem_curr_price,
    input  logic                                      i_mem_buffer_full,
    input  logic                                      i_mem_data_valid,
    output logic [FP_WORD_SIZE-1:0]                   o_volatility,
    output logic [DATA_WIDTH-1:0]                     o_price,
    output logic [$clog2(NUM_STOCKS)-1:0]             o_stock_id,
    output logic                                      o_buffer_full,
    output logic                                      o_valid,
    output logic                                      o_error
);

    localparam int unsigned S_W = $clog2(NUM_STOCKS);
    localparam int unsigned P_W = $clog2(BUFFER_SIZE);
    localparam int unsigned C_W = $clog2(TIMEOUT + 1);

    sched_state_t state_q, state_d;

    logic [P_W-1:0]        wr_ptr [NUM_STOCKS];
    logic [S_W-1:0]        stock_q;
    logic [DATA_WIDTH-1:0] ask_q, bid_q;
    logic [C_W-1:0]        cnt_q;
    logic [NUM_STOCKS-1:0] grant_onehot;
    logic [S_W-1:0]        grant_idx;
    logic                  take;

    // The pointer advances at the grant edge rather than in ISSUE; it is only
    // consulted in IDLE, so the next arbitration sees the same priority.
    rr_arbiter #(.N(NUM_STOCKS)) u_arb (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_req          (i_req),
        .i_advance      (take),
        .o_grant_onehot (grant_onehot),
        .o_grant_idx    (grant_idx)
    );

    assign o_mem_buffer_size            = DATA_WIDTH'(BUFFER_SIZE);
    assign o_mem_buffer_size_reciprocal = FP_WORD_SIZE'(recip_q32(BUFFER_SIZE));
    // Power-of-2 window makes stock_id*BUFFER_SIZE + ptr a plain concatenation.
    assign o_mem_write_address          = {stock_q, wr_ptr[stock_q]};
    assign o_mem_stock_id               = stock_q;
    assign o_mem_best_ask               = ask_q;
    assign o_mem_best_bid               = bid_q;

    always_comb begin
        state_d     = state_q;
        o_ready     = '0;
        o_mem_valid = 1'b0;
        take        = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = grant_onehot;
                if (|i_req) begin
                    take    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                o_mem_valid = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                if (i_mem_data_valid || cnt_q == C_W'(TIMEOUT - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q       <= IDLE;
            for (int unsigned s = 0; s < NUM_STOCKS; s++) wr_ptr[s] <= '0;
            stock_q       <= '0;
            ask_q         <= '0;
            bid_q         <= '0;
            cnt_q         <= '0;
            o_volatility  <= '0;
            o_price       <= '0;
            o_stock_id    <= '0;
            o_buffer_full <= 1'b0;
            o_valid       <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            state_q <= state_d;
            o_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take) begin
                        stock_q <= grant_idx;
                        ask_q   <= i_best_ask[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                        bid_q   <= i_best_bid[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                ISSUE: begin
                    wr_ptr[stock_q] <= wr_ptr[stock_q] + P_W'(1);
                    cnt_q           <= '0;
                end
                WAIT: begin
                    if (i_mem_data_valid) begin
                        o_volatility  <= i_mem_volatility;
                        o_price       <= i_mem_curr_price;
                        o_buffer_full <= i_mem_buffer_full;
                        o_stock_id    <= stock_q;
                        o_valid       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + C_W'(1);
                        if (cnt_q == C_W'(TIMEOUT - 1)) o_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_volatility_scheduler.sv
// Randomized bench for volatility_scheduler against a transaction-level model.
module tb_volatility_scheduler;

    localparam int NS  = 4;
    localparam int BS  = 32;
    localparam int DW  = 32;
    localparam int FW  = 64;
    localparam int TMO = 4;

    logic           i_clk = 1'b0;
    logic           i_reset_n;
    logic [NS-1:0]  i_req;
    logic [NS*DW-1:0] i_best_ask, i_best_bid;
    logic [NS-1:0]  o_ready;
    logic [6:0]     o_mem_write_address;
    logic [DW-1:0]  o_mem_best_ask, o_mem_best_bid;
    logic [1:0]     o_mem_stock_id;
    logic           o_mem_valid;
    logic [DW-1:0]  o_mem_buffer_size;
    logic [FW-1:0]  o_mem_buffer_size_reciprocal;
    logic [FW-1:0]  i_mem_volatility;
    logic [DW-1:0]  i_mem_curr_price;
    logic           i_mem_buffer_full;
    logic           i_mem_data_valid;
    logic [FW-1:0]  o_volatility;
    logic [DW-1:0]  o_price;
    logic [1:0]     o_stock_id;
    logic           o_buffer_full;
    logic           o_valid;
    logic           o_error;

    volatility_scheduler #(
        .FP_WORD_SIZE (FW),
        .DATA_WIDTH   (DW),
        .BUFFER_SIZE  (BS),
        .NUM_STOCKS   (NS),
        .TIMEOUT      (TMO)
    ) dut (
        .i_clk                        (i_clk),
        .i_reset_n                    (i_reset_n),
        .i_req                        (i_req),
        .i_best_ask                   (i_best_ask),
        .i_best_bid                   (i_best_bid),
        .o_ready                      (o_ready),
        .o_mem_write_address          (o_mem_write_address),
        .o_mem_best_ask               (o_mem_best_ask),
        .o_mem_best_bid               (o_mem_best_bid),
        .o_mem_stock_id               (o_mem_stock_id),
        .o_mem_valid                  (o_mem_valid),
        .o_mem_buffer_size            (o_mem_buffer_size),
        .o_mem_buffer_size_reciprocal (o_mem_buffer_size_reciprocal),
        .i_mem_volatility             (i_mem_volatility),
        .i_mem_curr_price             (i_mem_curr_price),
        .i_mem_buffer_full            (i_mem_buffer_full),
        .i_mem_data_valid             (i_mem_data_valid),
        .o_volatility                 (o_volatility),
        .o_price                      (o_price),
        .o_stock_id                   (o_stock_id),
        .o_buffer_full                (o_buffer_full),
        .o_valid                      (o_valid),
        .o_error                      (o_error)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: priority pointer, write pointers, memory fill counts, sticky error.
    int m_ptr;
    int m_wr   [NS];
    int m_fill [NS];
    bit m_err;

    logic [DW-1:0] ask [NS];
    logic [DW-1:0] bid [NS];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int model_pick(input logic [NS-1:0] r);
        for (int k = 0; k < NS; k++)
            if (r[(m_ptr + k) % NS]) return (m_ptr + k) % NS;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_err = 0;
        for (int s = 0; s < NS; s++) begin
            m_wr[s]   = 0;
            m_fill[s] = 0;
        end
    endtask

    task automatic drive_prices();
        for (int s = 0; s < NS; s++) begin
            i_best_ask[s*DW +: DW] = ask[s];
            i_best_bid[s*DW +: DW] = bid[s];
        end
    endtask

    task automatic random_prices();
        for (int s = 0; s < NS; s++) begin
            ask[s] = $urandom;
            bid[s] = $urandom;
        end
        drive_prices();
    endtask

    task automatic junk_mem(input logic dv);
        i_mem_data_valid  = dv;
        i_mem_volatility  = {$urandom, $urandom};
        i_mem_curr_price  = $urandom;
        i_mem_buffer_full = 1'($urandom);
    endtask

    task automatic check_consts(input string tag);
        check({tag, "_bufsize"}, o_mem_buffer_size, 64'd32);
        check({tag, "_recip"}, o_mem_buffer_size_reciprocal, 64'h0000_0000_0800_0000);
    endtask

    // One full update starting in an IDLE cycle at a negedge with i_req already set.
    // delay >= TMO means the memory never answers.
    task automatic run_txn(input int delay, input logic [NS-1:0] req_after, output int g);
        logic [DW-1:0] la, lb;
        logic [FW-1:0] vol;
        logic [DW-1:0] px;
        logic          fl;
        bit            got;
        #1;
        g = model_pick(i_req);
        if (g < 0) begin
            check("ready_none", 64'(o_ready), 64'd0);
            return;
        end
        check("ready_onehot", 64'(o_ready), 64'(1) << g);
        la = ask[g];
        lb = bid[g];
        @(posedge i_clk); @(negedge i_clk);
        check("mem_valid", 64'(o_mem_valid), 64'd1);
        check("mem_addr", 64'(o_mem_write_address), 64'(g * BS + m_wr[g]));
        check("mem_id", 64'(o_mem_stock_id), 64'(g));
        check("mem_ask", 64'(o_mem_best_ask), 64'(la));
        check("mem_bid", 64'(o_mem_best_bid), 64'(lb));
        check("ready_busy", 64'(o_ready), 64'd0);
        check("valid_pulse", 64'(o_valid), 64'd0);
        check_consts("issue");
        m_wr[g]   = (m_wr[g] + 1) % BS;
        m_ptr     = (g + 1) % NS;
        m_fill[g] = m_fill[g] + 1;
        // Response strobe during ISSUE and a shifting request/price picture must be ignored.
        i_req = 4'($urandom);
        random_prices();
        junk_mem(1'($urandom));
        got = 0;
        for (int w = 0; w < TMO && !got; w++) begin
            @(posedge i_clk); @(negedge i_clk);
            check("wait_mem_valid", 64'(o_mem_valid), 64'd0);
            check("wait_ready", 64'(o_ready), 64'd0);
            check("wait_id_held", 64'(o_mem_stock_id), 64'(g));
            check("wait_ask_held", 64'(o_mem_best_ask), 64'(la));
            check("wait_no_valid", 64'(o_valid), 64'd0);
            i_req = 4'($urandom);
            if (w == delay) begin
                vol = {$urandom, $urandom};
                px  = DW'(({1'b0, la} + {1'b0, lb}) >> 1);
                fl  = (m_fill[g] >= BS);
                i_mem_data_valid  = 1'b1;
                i_mem_volatility  = vol;
                i_mem_curr_price  = px;
                i_mem_buffer_full = fl;
                got = 1;
            end else begin
                junk_mem(1'b0);
            end
        end
        i_req = req_after;
        @(posedge i_clk); @(negedge i_clk);
        junk_mem(1'b0);
        if (got) begin
            check("o_valid", 64'(o_valid), 64'd1);
            check("o_volatility", o_volatility, vol);
            check("o_price", 64'(o_price), 64'(px));
            check("o_full", 64'(o_buffer_full), 64'(fl));
            check("o_stock_id", 64'(o_stock_id), 64'(g));
        end else begin
            m_err = 1;
            check("timeout_no_valid", 64'(o_valid), 64'd0);
        end
        check("o_error", 64'(o_error), 64'(m_err));
    endtask

    task automatic apply_reset();
        i_reset_n = 1'b0;
        i_req     = '0;
        junk_mem(1'b0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_ready", 64'(o_ready), 64'd0);
        check("rst_mem_valid", 64'(o_mem_valid), 64'd0);
        check("rst_addr", 64'(o_mem_write_address), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_error", 64'(o_error), 64'd0);
        check("rst_vol", o_volatility, 64'd0);
        check("rst_price", 64'(o_price), 64'd0);
        check_consts("rst");
        i_reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int g;
        i_reset_n = 1'b0;
        i_req     = '0;
        for (int s = 0; s < NS; s++) begin
            ask[s] = '0;
            bid[s] = '0;
        end
        drive_prices();
        junk_mem(1'b0);
        model_reset();
        apply_reset();

        // Single update to stock 2.
        ask[2] = 102;
        bid[2] = 98;
        drive_prices();
        i_req = 4'b0100;
        run_txn(0, 4'b0000, g);
        check("t1_grant", 64'(g), 64'd2);
        check("t1_price", 64'(o_price), 64'd100);

        // Lone requester, enough updates to wrap its window.
        i_req = 4'b0010;
        for (int k = 0; k < BS + 2; k++) begin
            random_prices();
            i_req = 4'b0010;
            run_txn(int'($urandom_range(0, TMO - 1)), 4'b0010, g);
            check("t2_grant", 64'(g), 64'd1);
        end

        // All stocks requesting from a fresh pointer.
        apply_reset();
        i_req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            i_req = 4'b1111;
            run_txn(0, 4'b1111, g);
            check("t3_order", 64'(g), 64'(k % NS));
        end

        // Memory never answers, then normal service resumes with error sticky.
        i_req = 4'b0001;
        run_txn(TMO, 4'b0100, g);
        i_req = 4'b0100;
        run_txn(1, 4'b0000, g);
        check("t4_recover", 64'(g), 64'd2);

        // Reset while waiting on the memory.
        i_req = 4'b0001;
        #1;
        @(posedge i_clk); @(negedge i_clk);
        i_req = '0;
        @(posedge i_clk); @(negedge i_clk);
        check("t5_in_wait", 64'(o_mem_valid), 64'd0);
        i_reset_n = 1'b0;
        junk_mem(1'b1);
        @(posedge i_clk); @(negedge i_clk);
        check("t5_rst_valid", 64'(o_valid), 64'd0);
        i_reset_n = 1'b1;
        junk_mem(1'b0);
        model_reset();
        @(posedge i_clk); @(negedge i_clk);
        check("t5_post_valid", 64'(o_valid), 64'd0);
        check("t5_post_error", 64'(o_error), 64'd0);
        random_prices();
        i_req = 4'b1000;
        #1;
        check("t5_ready", 64'(o_ready), 64'b1000);
        @(posedge i_clk); @(negedge i_clk);
        check("t5_addr", 64'(o_mem_write_address), 64'd96);
        m_wr[3] = 1; m_ptr = 0; m_fill[3] = 1;
        i_req = '0;
        for (int w = 0; w < TMO + 1; w++) begin
            @(posedge i_clk); @(negedge i_clk);
        end
        m_err = 1;
        check("t5_error", 64'(o_error), 64'd1);

        // Random request mixes and response delays.
        i_req = 4'($urandom_range(1, 15));
        for (int k = 0; k < 40; k++) begin
            random_prices();
            run_txn(($urandom_range(0, 7) == 0) ? TMO : int'($urandom_range(0, TMO - 1)),
                    4'($urandom_range(1, 15)), g);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
